alu_share_arb: RTL and testbench

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_share_arb.sv | 130 +++++++++++++
 tb/tb_alu_share_arb.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: arbitrates two requesters onto one shared combinational ALU.
// Each request is served in three one-cycle steps. In IDLE it is accepted,
// the operands are registered and the grant is recorded. In EXEC the ALU
// result is captured. In RESP the result is held until the requester takes it.
// When both requesters are valid, the grant goes round-robin between them.
module alu_share_arb #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_a,
  input  logic [XLEN-1:0]  req0_b,
  input  logic [3:0]       req0_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [XLEN-1:0]  rsp0_result,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_a,
  input  logic [XLEN-1:0]  req1_b,
  input  logic [3:0]       req1_sel,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [XLEN-1:0]  rsp1_result,
  // shared ALU
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_sel,
  input  logic [XLEN-1:0]  alu_result,
  // status
  output logic             busy,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  logic            last_gnt;   // requester granted most recently
  logic            gnt_id;     // requester owning the operation in flight
  logic            gnt_sel;    // requester chosen by the arbiter this cycle
  logic            accept;
  logic            rsp_take;
  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;
  logic [3:0]      sel_op;

  // Round-robin choice; a lone valid requester wins regardless of the pointer
  always_comb begin
    gnt_sel = 1'b0;
    if (req0_valid && req1_valid) gnt_sel = ~last_gnt;
    else if (req0_valid)          gnt_sel = 1'b0;
    else if (req1_valid)          gnt_sel = 1'b1;
    accept     = (state == S_IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !gnt_sel;
    req1_ready = accept &&  gnt_sel;
    sel_a      = gnt_sel ? req1_a   : req0_a;
    sel_b      = gnt_sel ? req1_b   : req0_b;
    sel_op     = gnt_sel ? req1_sel : req0_sel;
    rsp_take   = gnt_id  ? rsp1_ready : rsp0_ready;
  end

  // Control FSM with registered operand, response and counter outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      last_gnt    <= 1'b1;  // so requester 0 wins the first contended grant
      gnt_id      <= 1'b0;
      busy        <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp1_result <= '0;
      grant_cnt0  <= '0;
      grant_cnt1  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            alu_a    <= sel_a;
            alu_b    <= sel_b;
            alu_sel  <= sel_op;
            gnt_id   <= gnt_sel;
            last_gnt <= gnt_sel;
            busy     <= 1'b1;
            state    <= S_EXEC;
            if (gnt_sel) grant_cnt1 <= grant_cnt1 + 1'b1;
            else         grant_cnt0 <= grant_cnt0 + 1'b1;
          end
        end
        S_EXEC: begin
          if (gnt_id) begin
            rsp1_result <= alu_result;
            rsp1_valid  <= 1'b1;
          end else begin
            rsp0_result <= alu_result;
            rsp0_valid  <= 1'b1;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          // No new request is taken on this edge; arbitration resumes from IDLE
          if (rsp_take) begin
            if (gnt_id) rsp1_valid <= 1'b0;
            else        rsp0_valid <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb. It uses a small reference ALU with these op codes:
// 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, anything else 0.
// CNT_W is 2 so that grant counter wrap is reachable.
module tb_alu_share_arb;
  localparam int XLEN  = 32;
  localparam int CNT_W = 2;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                         OP_OR  = 4'd3, OP_XOR = 4'd4;

  logic             clk, reset;
  logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [XLEN-1:0]  req0_a, req0_b, rsp0_result;
  logic [3:0]       req0_sel;
  logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [XLEN-1:0]  req1_a, req1_b, rsp1_result;
  logic [3:0]       req1_sel;
  logic [XLEN-1:0]  alu_a, alu_b, alu_result;
  logic [3:0]       alu_sel;
  logic             busy;
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

  int checks   = 0;
  int failures = 0;

  alu_share_arb #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .busy(busy), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  function automatic logic [XLEN-1:0] alu_ref(logic [3:0] s, logic [XLEN-1:0] a,
                                              logic [XLEN-1:0] b);
    case (s)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_sel, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_sel = '0; rsp0_ready = 1;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_sel = '0; rsp1_ready = 1;
  endtask

  // Pulse reset and release it at a falling edge
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp0_valid"}, rsp0_valid, 0);
    chk({tag, "_rsp1_valid"}, rsp1_valid, 0);
    chk({tag, "_rsp0_result"}, rsp0_result, 0);
    chk({tag, "_rsp1_result"}, rsp1_result, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_sel"}, alu_sel, 0);
    chk({tag, "_cnt0"}, grant_cnt0, 0);
    chk({tag, "_cnt1"}, grant_cnt1, 0);
  endtask

  // Runs one lone req0 operation with rsp0_ready high, starting just after a falling edge
  task automatic run_req0(input string name, input logic [3:0] s, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res,
                          input logic [CNT_W-1:0] exp_cnt);
    @(negedge clk);
    req0_valid = 1; req0_a = a; req0_b = b; req0_sel = s; rsp0_ready = 1;
    #1;
    chk({name, "_ready"}, req0_ready, 1);
    chk({name, "_ready1"}, req1_ready, 0);
    @(negedge clk);
    req0_valid = 0;
    chk({name, "_exec_valid"}, rsp0_valid, 0);
    chk({name, "_exec_busy"}, busy, 1);
    chk({name, "_exec_ready"}, req0_ready, 0);
    @(negedge clk);
    chk({name, "_rsp_valid"}, rsp0_valid, 1);
    chk({name, "_result"}, rsp0_result, exp_res);
    chk({name, "_cnt0"}, grant_cnt0, exp_cnt);
    @(negedge clk);
    chk({name, "_done_valid"}, rsp0_valid, 0);
    chk({name, "_done_busy"}, busy, 0);
  endtask

  typedef struct {
    string           name;
    logic [3:0]      sel;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
  } vec_t;

  vec_t vecs[$];

  // Random-phase model state
  bit              mv[2], mr[2];
  logic [XLEN-1:0] ma[2], mb[2], exp_res[2], m_alu_a, m_alu_b, out_res;
  logic [3:0]      ms[2], m_alu_sel;
  int              acc[2];
  bit              out_act, last;
  int              out_id, out_age;

  initial begin
    reset = 1;
    clear_inputs();
    vecs.push_back('{"add_5_3",   OP_ADD, 32'd5,        32'd3,      32'd8});
    vecs.push_back('{"sub_wrap",  OP_SUB, 32'h100,      32'h7F,     32'h81});
    vecs.push_back('{"and_5_3",   OP_AND, 32'd5,        32'd3,      32'd1});
    vecs.push_back('{"or_7_2",    OP_OR,  32'd7,        32'd2,      32'd7});
    vecs.push_back('{"xor",       OP_XOR, 32'hF0F0,     32'h0FF0,   32'hFF00});
    vecs.push_back('{"add_ovf",   OP_ADD, 32'hFFFFFFFF, 32'd1,      32'd0});
    vecs.push_back('{"sub_under", OP_SUB, 32'd0,        32'd1,      32'hFFFFFFFF});

    // Reset values
    do_reset();
    #1;
    chk_reset_vals("rst");
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);

    // Table: lone req0 operations, counter wraps at 4
    foreach (vecs[i])
      run_req0(vecs[i].name, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].res,
               CNT_W'(i + 1));

    // Contention from reset: req0 wins first, then req1
    reset = 1;
    req0_valid = 1; req0_a = 5; req0_b = 3; req0_sel = OP_AND;
    req1_valid = 1; req1_a = 7; req1_b = 2; req1_sel = OP_OR;
    do_reset();
    #1;
    chk("cont_ready0", req0_ready, 1);
    chk("cont_ready1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    chk("cont_rsp0_valid", rsp0_valid, 1);
    chk("cont_rsp0_result", rsp0_result, 1);
    chk("cont_r1_blocked", req1_ready, 0);
    @(negedge clk);
    chk("cont_ready1_late", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    chk("cont_rsp1_valid", rsp1_valid, 1);
    chk("cont_rsp1_result", rsp1_result, 7);
    chk("cont_rsp0_quiet", rsp0_valid, 0);
    chk("cont_cnt0", grant_cnt0, 1);
    chk("cont_cnt1", grant_cnt1, 1);
    @(negedge clk);

    // Both held valid for six grants: strict alternation
    clear_inputs();
    do_reset();
    req0_valid = 1; req0_sel = OP_ADD; req0_a = 1; req0_b = 1;
    req1_valid = 1; req1_sel = OP_ADD; req1_a = 2; req1_b = 2;
    for (int k = 0; k < 6; k++) begin
      int waited;
      waited = 0;
      #1;
      while (!(req0_ready || req1_ready) && waited < 10) begin
        @(negedge clk); #1; waited++;
      end
      chk("alt_timeout", waited < 10, 1);
      chk("alt_grant", req1_ready, k % 2);
      chk("alt_onehot", req0_ready ^ req1_ready, 1);
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    repeat (3) @(negedge clk);
    chk("alt_cnt0", grant_cnt0, 3);
    chk("alt_cnt1", grant_cnt1, 3);

    // Stalled response on requester 1
    clear_inputs();
    do_reset();
    req1_valid = 1; req1_a = 32'h100; req1_b = 32'h7F; req1_sel = OP_SUB; rsp1_ready = 0;
    #1;
    chk("stall_ready1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    req0_valid = 1; req0_a = 1; req0_b = 1; req0_sel = OP_ADD;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("stall_rsp1_valid", rsp1_valid, 1);
      chk("stall_rsp1_result", rsp1_result, 32'h81);
      chk("stall_busy", busy, 1);
      chk("stall_ready0", req0_ready, 0);
      chk("stall_rsp0_valid", rsp0_valid, 0);
      chk("stall_rsp0_result", rsp0_result, 0);
      if (k == 4) rsp1_ready = 1;
      @(negedge clk);
    end
    chk("stall_cleared", rsp1_valid, 0);
    chk("stall_idle", busy, 0);
    chk("stall_no_early_accept", grant_cnt0, 0);
    chk("stall_ready0_after", req0_ready, 1);
    req0_valid = 0;

    // Reset asserted while in RESP aborts the operation
    clear_inputs();
    do_reset();
    req0_valid = 1; req0_a = 2; req0_b = 2; req0_sel = OP_ADD; rsp0_ready = 0;
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    chk("abort_in_resp", rsp0_valid, 1);
    reset = 1;
    #1;
    chk_reset_vals("abort");
    @(negedge clk);
    reset = 0;
    rsp0_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_rsp0", rsp0_valid, 0);
      chk("abort_no_busy", busy, 0);
    end

    // Counter wrap sequence 1,2,3,0,1
    clear_inputs();
    do_reset();
    for (int k = 0; k < 5; k++)
      run_req0("wrap", OP_ADD, XLEN'(k), 32'd10, XLEN'(k + 10), CNT_W'(k + 1));

    // Randomized traffic against a transaction-level scoreboard
    clear_inputs();
    do_reset();
    out_act = 0; last = 1; acc[0] = 0; acc[1] = 0;
    exp_res[0] = '0; exp_res[1] = '0;
    m_alu_a = '0; m_alu_b = '0; m_alu_sel = '0;
    mv[0] = 0; mv[1] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int g;
      for (int r = 0; r < 2; r++) begin
        if (mv[r]) begin
          if ($urandom_range(0, 9) == 0) mv[r] = 0;
        end else if ($urandom_range(0, 1) == 1) begin
          mv[r] = 1; ma[r] = $urandom; mb[r] = $urandom;
          ms[r] = 4'($urandom_range(0, 5));
        end
        mr[r] = ($urandom_range(0, 9) < 7);
      end
      req0_valid = mv[0]; req0_a = ma[0]; req0_b = mb[0]; req0_sel = ms[0]; rsp0_ready = mr[0];
      req1_valid = mv[1]; req1_a = ma[1]; req1_b = mb[1]; req1_sel = ms[1]; rsp1_ready = mr[1];
      #1;
      g = -1;
      if (!out_act) begin
        if (mv[0] && mv[1]) g = last ? 0 : 1;
        else if (mv[0])     g = 0;
        else if (mv[1])     g = 1;
      end
      chk("rnd_busy", busy, out_act);
      chk("rnd_ready0", req0_ready, g == 0);
      chk("rnd_ready1", req1_ready, g == 1);
      chk("rnd_rsp0_valid", rsp0_valid, out_act && out_id == 0 && out_age >= 1);
      chk("rnd_rsp1_valid", rsp1_valid, out_act && out_id == 1 && out_age >= 1);
      chk("rnd_rsp0_result", rsp0_result, exp_res[0]);
      chk("rnd_rsp1_result", rsp1_result, exp_res[1]);
      chk("rnd_cnt0", grant_cnt0, acc[0] % 4);
      chk("rnd_cnt1", grant_cnt1, acc[1] % 4);
      chk("rnd_alu_a", alu_a, m_alu_a);
      chk("rnd_alu_b", alu_b, m_alu_b);
      chk("rnd_alu_sel", alu_sel, m_alu_sel);
      // Advance the model across the coming rising edge
      if (out_act) begin
        if (out_age == 0) begin
          exp_res[out_id] = out_res;
          out_age = 1;
        end else if (mr[out_id]) begin
          out_act = 0;
        end
      end else if (g >= 0) begin
        out_act = 1; out_id = g; out_age = 0; last = (g == 1);
        out_res = alu_ref(ms[g], ma[g], mb[g]);
        m_alu_a = ma[g]; m_alu_b = mb[g]; m_alu_sel = ms[g];
        acc[g]++;
        mv[g] = 0;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time guard so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "time limit");
  end
endmodule
